// File: rtl/ysyx_25030093_mem_arb_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, owner IDs
// and the latched request payload.
package ysyx_25030093_mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/ysyx_25030093_rr_arb2.sv
// Combinational two-master grant.
//   ifu_req, lsu_req : pending requests
//   last_owner       : owner of the last completed transaction (0=IFU, 1=LSU)
//   rr_en            : 1 = round-robin, 0 = LSU has fixed priority
//   grant_valid      : some master is granted
//   grant_owner      : granted master ID
module ysyx_25030093_rr_arb2
    import ysyx_25030093_mem_arb_pkg::*;
(
    input  logic ifu_req,
    input  logic lsu_req,
    input  logic last_owner,
    input  logic rr_en,
    output logic grant_valid,
    output logic grant_owner
);

    // On contention, round-robin favours whoever did not own the last transaction.
    always_comb begin
        grant_valid = ifu_req | lsu_req;
        grant_owner = 1'(OWN_IFU);
        if (ifu_req && lsu_req) begin
            if (rr_en && (last_owner == 1'(OWN_LSU))) begin
                grant_owner = 1'(OWN_IFU);
            end else begin
                grant_owner = 1'(OWN_LSU);
            end
        end else if (lsu_req) begin
            grant_owner = 1'(OWN_LSU);
        end
    end

endmodule

// File: rtl/ysyx_25030093_mem_arb.sv
// Arbitrates the IFU and LSU onto a single memory port, one transaction at
// a time, with a WAIT-phase timeout that returns a bus error to the owner.
//   clk, rst           : clock, synchronous active-high reset
//   ifu_req_* / ifu_*  : IFU read request and response
//   lsu_req_* / lsu_*  : LSU read/write request and response
//   mem_req_* / mem_*  : downstream memory request and response
// Handshake outputs are combinational views of the registered FSM state.
module ysyx_25030093_mem_arb
    import ysyx_25030093_mem_arb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd1024,
    parameter logic        RR_EN   = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_rdata
);

    arb_state_e       state_q, state_d;
    mem_req_t         req_q, req_d;
    owner_e           owner_q, owner_d;
    owner_e           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_valid;
    logic             grant_owner;
    logic             owner_rdy;

    ysyx_25030093_rr_arb2 u_rr_arb2 (
        .ifu_req     (ifu_req_valid),
        .lsu_req     (lsu_req_valid),
        .last_owner  (last_q),
        .rr_en       (RR_EN),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // State and transaction context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_wen   = req_q.wen;
    assign mem_wdata = req_q.wdata;
    assign mem_wmask = req_q.wmask;

    // Next-state and handshake outputs; everything is held quiet while rst is high.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        owner_d        = owner_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        ifu_err        = 1'b0;
        lsu_err        = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        owner_rdy      = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_d = owner_e'(grant_owner);
                        state_d = ST_REQ;
                        if (grant_owner == 1'(OWN_LSU)) begin
                            lsu_req_ready = 1'b1;
                            req_d = '{addr: lsu_addr, wen: lsu_wen,
                                      wdata: lsu_wdata, wmask: lsu_wmask};
                        end else begin
                            ifu_req_ready = 1'b1;
                            req_d = '{addr: ifu_addr, wen: 1'b0,
                                      wdata: '0, wmask: 4'hF};
                        end
                    end
                end
                ST_REQ: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT: begin
                    mem_resp_ready = owner_rdy;
                    if (owner_q == OWN_LSU) begin
                        lsu_resp_valid = mem_resp_valid;
                        lsu_rdata      = mem_rdata;
                    end else begin
                        ifu_resp_valid = mem_resp_valid;
                        ifu_rdata      = mem_rdata;
                    end
                    // A response on the final allowed cycle still wins over the timeout.
                    if (mem_resp_valid && owner_rdy) begin
                        last_d  = owner_q;
                        state_d = ST_IDLE;
                    end else if (cnt_q == (TIMEOUT - 16'd1)) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_ERR: begin
                    if (owner_q == OWN_LSU) begin
                        lsu_resp_valid = 1'b1;
                        lsu_err        = 1'b1;
                    end else begin
                        ifu_resp_valid = 1'b1;
                        ifu_err        = 1'b1;
                    end
                    if (owner_rdy) begin
                        last_d  = owner_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_mem_arb.sv
// Directed bench: dut_a is round-robin, dut_b is fixed priority; both use an
// 8-cycle timeout and share every input.
module tb_ysyx_25030093_mem_arb;
    import ysyx_25030093_mem_arb_pkg::*;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_resp_ready;
    logic [31:0] ifu_addr;
    logic        lsu_req_valid, lsu_wen, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_rdata;

    logic        a_ifu_req_ready, a_ifu_resp_valid, a_ifu_err;
    logic [31:0] a_ifu_rdata;
    logic        a_lsu_req_ready, a_lsu_resp_valid, a_lsu_err;
    logic [31:0] a_lsu_rdata;
    logic        a_mem_req_valid, a_mem_wen, a_mem_resp_ready;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wmask;

    logic        b_ifu_req_ready, b_ifu_resp_valid, b_ifu_err;
    logic [31:0] b_ifu_rdata;
    logic        b_lsu_req_ready, b_lsu_resp_valid, b_lsu_err;
    logic [31:0] b_lsu_rdata;
    logic        b_mem_req_valid, b_mem_wen, b_mem_resp_ready;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    // observations captured by run_pair_txn
    logic        a_gl, a_gi, b_gl, b_gi, a_rl, a_ri, b_rl, b_ri;
    logic [31:0] a_rd;

    ysyx_25030093_mem_arb #(.TIMEOUT(16'd8), .RR_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(a_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(a_ifu_rdata), .ifu_err(a_ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(a_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(a_lsu_rdata), .lsu_err(a_lsu_err),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(a_mem_addr), .mem_wen(a_mem_wen), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(a_mem_resp_ready), .mem_rdata(mem_rdata)
    );

    ysyx_25030093_mem_arb #(.TIMEOUT(16'd8), .RR_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(b_ifu_rdata), .ifu_err(b_ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(b_lsu_rdata), .lsu_err(b_lsu_err),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(b_mem_addr), .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(b_mem_resp_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); clear_inputs(); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    // One contended transaction: IDLE grant, REQ accept, WAIT response.
    task automatic run_pair_txn(input logic [31:0] rdata);
        @(negedge clk);
        ifu_req_valid = 1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1; lsu_addr = 32'h0000_2000; lsu_wen = 0;
        mem_req_ready = 0; mem_resp_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
        #1;
        a_gl = a_lsu_req_ready; a_gi = a_ifu_req_ready;
        b_gl = b_lsu_req_ready; b_gi = b_ifu_req_ready;
        @(negedge clk); mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = rdata;
        ifu_resp_ready = 1; lsu_resp_ready = 1;
        #1;
        a_rl = a_lsu_resp_valid; a_ri = a_ifu_resp_valid;
        a_rd = a_rl ? a_lsu_rdata : a_ifu_rdata;
        b_rl = b_lsu_resp_valid; b_ri = b_ifu_resp_valid;
    endtask

    task automatic test_reset();
        @(negedge clk); clear_inputs(); rst = 1; ifu_req_valid = 1; lsu_req_valid = 1;
        #1;
        n_checks++;
        if ({a_ifu_req_ready, a_lsu_req_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready_during_rst: got %b expected 00", {a_ifu_req_ready, a_lsu_req_ready});
        end
        @(negedge clk); clear_inputs(); rst = 0;
        #1;
        n_checks++;
        if (dut_a.state_q !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut_a.state_q, ST_IDLE);
        end
        n_checks++;
        if ({a_mem_req_valid, a_mem_resp_ready, a_ifu_resp_valid, a_lsu_resp_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valids: got %b expected 0000",
                {a_mem_req_valid, a_mem_resp_ready, a_ifu_resp_valid, a_lsu_resp_valid});
        end
        n_checks++;
        if ({a_mem_addr, a_mem_wen, a_mem_wdata, a_mem_wmask} !== 69'd0) begin
            n_fail++; $display("FAIL reset_payload: got %h expected 0", {a_mem_addr, a_mem_wen, a_mem_wdata, a_mem_wmask});
        end
    endtask

    task automatic test_ifu_read();
        pulse_reset();
        @(negedge clk); ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        n_checks++;
        if ({a_ifu_req_ready, a_lsu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL ifu_grant: got %b expected 10", {a_ifu_req_ready, a_lsu_req_ready});
        end
        @(negedge clk); ifu_req_valid = 0; ifu_addr = 32'h0; mem_req_ready = 1;
        #1;
        n_checks++;
        if ({a_mem_req_valid, a_mem_addr, a_mem_wen, a_mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'hF}) begin
            n_fail++; $display("FAIL ifu_mem_req: got %h expected %h",
                {a_mem_req_valid, a_mem_addr, a_mem_wen, a_mem_wmask}, {1'b1, 32'h8000_0000, 1'b0, 4'hF});
        end
        @(negedge clk); mem_req_ready = 0; ifu_resp_ready = 1;
        #1;
        n_checks++;
        if ({a_ifu_resp_valid, a_lsu_resp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL ifu_wait_quiet: got %b expected 00", {a_ifu_resp_valid, a_lsu_resp_valid});
        end
        @(negedge clk); mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        #1;
        n_checks++;
        if ({a_ifu_resp_valid, a_ifu_err, a_lsu_resp_valid, a_mem_resp_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL ifu_resp_flags: got %b expected 1001",
                {a_ifu_resp_valid, a_ifu_err, a_lsu_resp_valid, a_mem_resp_ready});
        end
        n_checks++;
        if (a_ifu_rdata !== 32'h0000_0413) begin
            n_fail++; $display("FAIL ifu_rdata: got %h expected 00000413", a_ifu_rdata);
        end
        @(negedge clk); clear_inputs();
        #1;
        n_checks++;
        if (dut_a.state_q !== ST_IDLE || a_ifu_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL ifu_done_idle: state %0d resp_valid %b expected 0/0", dut_a.state_q, a_ifu_resp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic exp_lsu;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            run_pair_txn(32'h100 + 32'(i));
            exp_lsu = (i % 2 == 0);
            n_checks++;
            if ({a_gl, a_gi} !== {exp_lsu, ~exp_lsu}) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got lsu/ifu %b%b expected %b%b", i, a_gl, a_gi, exp_lsu, ~exp_lsu);
            end
            n_checks++;
            if ({a_rl, a_ri} !== {exp_lsu, ~exp_lsu} || a_rd !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL rr_resp[%0d]: got lsu/ifu %b%b data %h expected %b%b data %h",
                    i, a_rl, a_ri, a_rd, exp_lsu, ~exp_lsu, 32'h100 + 32'(i));
            end
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_fixed_priority();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            run_pair_txn(32'h200 + 32'(i));
            n_checks++;
            if ({b_gl, b_gi, b_rl, b_ri} !== 4'b1010) begin
                n_fail++; $display("FAIL fixed_prio[%0d]: got grant %b%b resp %b%b expected 10 10", i, b_gl, b_gi, b_rl, b_ri);
            end
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_write_stall();
        logic [68:0] exp_pl;
        exp_pl = {32'h3000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011};
        pulse_reset();
        @(negedge clk);
        lsu_req_valid = 1; lsu_addr = 32'h3000_0010; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        #1;
        n_checks++;
        if ({a_lsu_req_ready, a_ifu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL wr_grant: got %b expected 10", {a_lsu_req_ready, a_ifu_req_ready});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wen = 0; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
            mem_req_ready = 0;
            #1;
            n_checks++;
            if (a_mem_req_valid !== 1'b1 || {a_mem_addr, a_mem_wen, a_mem_wdata, a_mem_wmask} !== exp_pl) begin
                n_fail++; $display("FAIL wr_stall[%0d]: got valid %b payload %h expected 1 %h", k, a_mem_req_valid,
                    {a_mem_addr, a_mem_wen, a_mem_wdata, a_mem_wmask}, exp_pl);
            end
        end
        @(negedge clk); mem_req_ready = 1;
        #1;
        n_checks++;
        if (a_mem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL wr_accept: got %b expected 1", a_mem_req_valid);
        end
        @(negedge clk); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0; lsu_resp_ready = 1;
        #1;
        n_checks++;
        if ({a_lsu_resp_valid, a_lsu_err, a_ifu_resp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL wr_resp: got %b expected 100", {a_lsu_resp_valid, a_lsu_err, a_ifu_resp_valid});
        end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_timeout();
        pulse_reset();
        @(negedge clk); ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
        @(negedge clk); ifu_req_valid = 0; mem_req_ready = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); mem_req_ready = 0;
            #1;
            n_checks++;
            if (dut_a.state_q !== ST_WAIT || a_ifu_resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL to_wait[%0d]: state %0d resp_valid %b expected %0d/0", k, dut_a.state_q, a_ifu_resp_valid, ST_WAIT);
            end
        end
        @(negedge clk); mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF; ifu_resp_ready = 0;
        #1;
        n_checks++;
        if (dut_a.state_q !== ST_ERR) begin
            n_fail++; $display("FAIL to_err_state: got %0d expected %0d", dut_a.state_q, ST_ERR);
        end
        n_checks++;
        if ({a_ifu_resp_valid, a_ifu_err, a_mem_resp_ready, a_lsu_resp_valid} !== 4'b1100 || a_ifu_rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_err_resp: got flags %b rdata %h expected 1100 00000000",
                {a_ifu_resp_valid, a_ifu_err, a_mem_resp_ready, a_lsu_resp_valid}, a_ifu_rdata);
        end
        @(negedge clk); mem_resp_valid = 0; ifu_resp_ready = 1;
        #1;
        n_checks++;
        if ({a_ifu_resp_valid, a_ifu_err} !== 2'b11) begin
            n_fail++; $display("FAIL to_err_hold: got %b expected 11", {a_ifu_resp_valid, a_ifu_err});
        end
        @(negedge clk); clear_inputs();
        #1;
        n_checks++;
        if (dut_a.state_q !== ST_IDLE || a_ifu_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL to_err_exit: state %0d resp_valid %b expected %0d/0", dut_a.state_q, a_ifu_resp_valid, ST_IDLE);
        end
    endtask

    task automatic test_timeout_boundary();
        pulse_reset();
        @(negedge clk); ifu_req_valid = 1; ifu_addr = 32'h8000_0104;
        @(negedge clk); ifu_req_valid = 0; mem_req_ready = 1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); mem_req_ready = 0;
        end
        @(negedge clk); mem_resp_valid = 1; mem_rdata = 32'h0000_1234; ifu_resp_ready = 1;
        #1;
        n_checks++;
        if ({a_ifu_resp_valid, a_ifu_err} !== 2'b10 || a_ifu_rdata !== 32'h0000_1234) begin
            n_fail++; $display("FAIL to_edge_resp: got %b data %h expected 10 00001234", {a_ifu_resp_valid, a_ifu_err}, a_ifu_rdata);
        end
        @(negedge clk); clear_inputs();
        #1;
        n_checks++;
        if (dut_a.state_q !== ST_IDLE) begin
            n_fail++; $display("FAIL to_edge_idle: got %0d expected %0d", dut_a.state_q, ST_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        @(negedge clk); ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
        @(negedge clk); ifu_req_valid = 0; mem_req_ready = 1;
        @(negedge clk); mem_req_ready = 0; ifu_resp_ready = 1;
        @(negedge clk); rst = 1;
        @(negedge clk); clear_inputs(); rst = 0;
        #1;
        n_checks++;
        if (dut_a.state_q !== ST_IDLE) begin
            n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", dut_a.state_q, ST_IDLE);
        end
        n_checks++;
        if ({a_ifu_resp_valid, a_mem_req_valid, a_mem_resp_ready, a_ifu_req_ready} !== 4'b0000
            || a_mem_addr !== 32'h0 || a_mem_wmask !== 4'h0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b addr %h mask %h expected 0000 0 0",
                {a_ifu_resp_valid, a_mem_req_valid, a_mem_resp_ready, a_ifu_req_ready}, a_mem_addr, a_mem_wmask);
        end
        @(negedge clk); ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
        #1;
        n_checks++;
        if (a_ifu_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_regrant: got %b expected 1", a_ifu_req_ready);
        end
        @(negedge clk); ifu_req_valid = 0;
        #1;
        n_checks++;
        if (a_mem_req_valid !== 1'b1 || a_mem_addr !== 32'h8000_0200) begin
            n_fail++; $display("FAIL rstmid_req: got %b %h expected 1 80000200", a_mem_req_valid, a_mem_addr);
        end
        pulse_reset();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_ifu_read();
        test_round_robin();
        test_fixed_priority();
        test_write_stall();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
